mix_block_out: RTL and testbench

- Parametrised successor to the MIX output unit. On `start`, fetches a block of BLOCK_WORDS 30-bit MIX words from memory, one word per request/load handshake.
- Splits each word into five 6-bit MIX characters, MSB first, and converts each to ASCII.
- Streams the ASCII bytes to a byte sink (UART transmitter) over a valid/ready handshake.
- Sits between the CPU's OUT instruction decode, main memory read port and the serial TX.

---
 rtl/mix_block_out.sv | 150 +++++++++++++++
 tb/tb_mix_block_out.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_block_out.sv
`default_nettype none
// mix_block_out: fetches BLOCK_WORDS MIX words from memory and streams them as ASCII bytes.
// Define MIX_BLOCK_OUT_CRLF_EN to append a CR/LF trailer to every block.
module mix_block_out #(
  parameter int         BLOCK_WORDS = 14,
  parameter int         ADDR_W      = 12,
  parameter logic [7:0] SUB_CHAR    = 8'h23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addressin,
  output logic [ADDR_W-1:0] addressout,
  output logic              request,
  input  logic              load,
  input  logic [29:0]       in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_TRAIL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'(BLOCK_WORDS - 1);

`ifdef MIX_BLOCK_OUT_CRLF_EN
  localparam state_t END_STATE = S_TRAIL;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      state;
  state_t      state_n;
  logic [7:0]  word_cnt;
  logic [2:0]  char_idx;
  logic [29:0] shreg;
`ifdef MIX_BLOCK_OUT_CRLF_EN
  logic        trail_idx;
`endif

  function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
    logic [7:0] c8;
    logic [7:0] r;
    c8 = {2'b00, code};
    r  = SUB_CHAR;
    if (code == 6'd0)                          r = 8'h20;
    else if (code <= 6'd9)                     r = c8 + 8'h40;
    else if (code >= 6'd11 && code <= 6'd19)   r = c8 + 8'h3F;
    else if (code >= 6'd22 && code <= 6'd29)   r = c8 + 8'h3D;
    else if (code >= 6'd30 && code <= 6'd39)   r = c8 + 8'h12;
    else begin
      case (code)
        6'd40: r = 8'h2E;  6'd41: r = 8'h2C;  6'd42: r = 8'h28;  6'd43: r = 8'h29;
        6'd44: r = 8'h2B;  6'd45: r = 8'h2D;  6'd46: r = 8'h2A;  6'd47: r = 8'h2F;
        6'd48: r = 8'h3D;  6'd49: r = 8'h24;  6'd50: r = 8'h3C;  6'd51: r = 8'h3E;
        6'd52: r = 8'h40;  6'd53: r = 8'h3B;  6'd54: r = 8'h3A;  6'd55: r = 8'h27;
        default: r = SUB_CHAR;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      addressout <= '0;
      word_cnt   <= '0;
      char_idx   <= '0;
      shreg      <= '0;
`ifdef MIX_BLOCK_OUT_CRLF_EN
      trail_idx  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (start) begin
          addressout <= addressin;
          word_cnt   <= '0;
        end
        S_WAIT: if (load) begin
          shreg    <= in;
          char_idx <= '0;
        end
        S_EMIT: if (tx_ready) begin
          // The current character always sits in the top six bits of shreg.
          if (char_idx == 3'd4) begin
            char_idx <= '0;
            if (word_cnt != LAST_WORD) begin
              addressout <= addressout + ADDR_W'(1);
              word_cnt   <= word_cnt + 8'd1;
            end
          end else begin
            char_idx <= char_idx + 3'd1;
            shreg    <= {shreg[23:0], 6'd0};
          end
        end
`ifdef MIX_BLOCK_OUT_CRLF_EN
        S_TRAIL: if (tx_ready) trail_idx <= ~trail_idx;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    request  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_REQ;
      S_REQ: begin
        request = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: if (load) state_n = S_EMIT;
      S_EMIT: begin
        tx_valid = 1'b1;
        tx_data  = mix_to_ascii(shreg[29:24]);
        if (tx_ready && char_idx == 3'd4)
          state_n = (word_cnt == LAST_WORD) ? END_STATE : S_REQ;
      end
`ifdef MIX_BLOCK_OUT_CRLF_EN
      S_TRAIL: begin
        tx_valid = 1'b1;
        tx_data  = trail_idx ? 8'h0A : 8'h0D;
        if (tx_ready && trail_idx) state_n = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mix_block_out.sv
`default_nettype none
// Bench for mix_block_out: randomized words, load latency and backpressure against a table-driven model.
module tb_mix_block_out;
  localparam int BW = 2;
  localparam int AW = 12;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] addressin = '0;
  logic          tx_ready  = 1'b0;
  logic          resp_load = 1'b0;
  logic          man_load  = 1'b0;
  logic [29:0]   resp_in   = '0;
  logic [29:0]   man_in    = '0;
  wire           load_w    = resp_load | man_load;
  wire  [29:0]   in_w      = man_load ? man_in : resp_in;
  logic [AW-1:0] addressout;
  logic          request;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;

  mix_block_out #(.BLOCK_WORDS(BW), .ADDR_W(AW), .SUB_CHAR(8'h23)) dut (
    .clk(clk), .reset(reset), .start(start), .addressin(addressin),
    .addressout(addressout), .request(request), .load(load_w), .in(in_w),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [29:0] mem [0:4095];
  int          lat = 2;
  bit          lat_rand = 1'b0;
  int          rdy_mode = 0;
  bit          mem_enable = 1'b1;
  logic [7:0]  got_q[$];
  int          req_q[$];
  int          done_cnt = 0, busy_viol = 0, stall_viol = 0, order_viol = 0;
  int          blk_bytes = 0, blk_reqs = 0;
  bit          stalled = 1'b0;
  logic [7:0]  last_data = '0;
  int          r_addr, r_lat;

  // Sink: 0 always ready, 1 toggling, 2 random, 3 held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom % 2);
      default: tx_ready = 1'b0;
    endcase
  end

  // Memory: answers each request after lat (or random 1..7) cycles.
  always begin
    @(negedge clk);
    if (request && mem_enable) begin
      r_addr = int'(addressout);
      r_lat  = lat_rand ? int'($urandom_range(1, 7)) : lat;
      repeat (r_lat) @(posedge clk);
      #1;
      resp_in   = mem[r_addr];
      resp_load = 1'b1;
      @(posedge clk);
      #1;
      resp_load = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (stalled && (tx_valid !== 1'b1 || tx_data !== last_data)) stall_viol++;
    stalled   = tx_valid && !tx_ready && reset;
    last_data = tx_data;
    if (start && !busy && !done) begin blk_bytes = 0; blk_reqs = 0; end
    if (tx_valid && tx_ready) begin got_q.push_back(tx_data); blk_bytes++; end
    if (request) begin
      if (blk_bytes != 5 * blk_reqs) order_viol++;
      blk_reqs++;
      req_q.push_back(int'(addressout));
    end
    if (done) begin done_cnt++; if (busy) busy_viol++; end
  end

  task automatic model_block(input int a, output logic [7:0] e[$], output int ea[$]);
    string tbl;
    int    word, code;
    tbl = " ABCDEFGHI#JKLMNOPQR##STUVWXYZ0123456789.,()+-*/=$<>@;:'########";
    e = {};
    ea = {};
    for (int w = 0; w < BW; w++) begin
      ea.push_back((a + w) % 4096);
      word = int'(mem[(a + w) % 4096]);
      for (int k = 4; k >= 0; k--) begin
        code = (word / (1 << (6 * k))) % 64;
        e.push_back(tbl[code]);
      end
    end
`ifdef MIX_BLOCK_OUT_CRLF_EN
    e.push_back(8'h0D);
    e.push_back(8'h0A);
`endif
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    start = 1'b1;
    addressin = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int c = 0;
    while (done_cnt == d0 && c < 4000) begin @(posedge clk); c++; end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({addressout, request, tx_data, tx_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h req=%b data=%h valid=%b busy=%b done=%b required all 0",
               addressout, request, tx_data, tx_valid, busy, done);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({request, tx_valid, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got req=%b valid=%b busy=%b done=%b required 0", request, tx_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    int         addrs[2];
    string      lit;
    logic [7:0] e[$];
    int         ea[$];
    int         b0, r0, d0;
    addrs = '{8, 50};
    lit = "ABCDEFG#JK";
    lat = 2; lat_rand = 1'b0; rdy_mode = 0;
    foreach (addrs[j]) begin
      b0 = got_q.size(); r0 = req_q.size(); d0 = done_cnt;
      do_start(AW'(addrs[j]));
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
      wait_done(d0);
      n_chk++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt - d0); end
      model_block(addrs[j], e, ea);
      n_chk++;
      if (got_q.size() - b0 != e.size()) begin
        n_fail++; $display("FAIL basic_len: got %0d bytes required %0d", got_q.size() - b0, e.size());
      end
      foreach (e[i]) if (b0 + i < got_q.size()) begin
        n_chk++;
        if (got_q[b0 + i] !== e[i]) begin n_fail++; $display("FAIL basic_byte[%0d]: got %h required %h", i, got_q[b0 + i], e[i]); end
      end
      foreach (ea[i]) begin
        n_chk++;
        if (r0 + i >= req_q.size() || req_q[r0 + i] != ea[i]) begin
          n_fail++; $display("FAIL basic_addr[%0d]: got %0d requests required address %0d", i, req_q.size() - r0, ea[i]);
        end
      end
      if (j == 0) begin
        for (int i = 0; i < 10; i++) begin
          n_chk++;
          if (b0 + i >= got_q.size() || got_q[b0 + i] !== lit[i]) begin
            n_fail++; $display("FAIL basic_text[%0d]: required %h", i, lit[i]);
          end
        end
      end
    end
    n_chk++;
    if (busy_viol != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_fall: got %0d busy-with-done cycles, busy=%b required 0", busy_viol, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e[$];
    int         ea[$];
    int         b0, d0, c, sv0, ov0, hold_n;
    logic [7:0] d;
    for (int w = 0; w < BW; w++) mem[200 + w] = 30'($urandom);
    lat = 3; lat_rand = 1'b0; rdy_mode = 1;
    b0 = got_q.size(); d0 = done_cnt; sv0 = stall_viol; ov0 = order_viol;
    do_start(AW'(200));
    c = 0;
    while (got_q.size() < b0 + 2 && c < 200) begin @(posedge clk); c++; end
    @(negedge clk);
    rdy_mode = 3;
    @(posedge clk);
    @(negedge clk);
    d = tx_data;
    hold_n = got_q.size();
    n_chk++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_at_stall: got %b required 1", tx_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (tx_valid !== 1'b1 || tx_data !== d) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h required 1/%h", i, tx_valid, tx_data, d);
      end
    end
    n_chk++;
    if (got_q.size() != hold_n) begin n_fail++; $display("FAIL bp_no_accept: got %0d bytes required %0d", got_q.size(), hold_n); end
    rdy_mode = 1;
    wait_done(d0);
    rdy_mode = 0;
    model_block(200, e, ea);
    n_chk++;
    if (got_q.size() - b0 != e.size()) begin
      n_fail++; $display("FAIL bp_len: got %0d bytes required %0d", got_q.size() - b0, e.size());
    end
    foreach (e[i]) if (b0 + i < got_q.size()) begin
      n_chk++;
      if (got_q[b0 + i] !== e[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h required %h", i, got_q[b0 + i], e[i]); end
    end
    n_chk++;
    if (stall_viol != sv0 || order_viol != ov0) begin
      n_fail++; $display("FAIL bp_protocol: got %0d unstable stalls, %0d early requests required 0",
                         stall_viol - sv0, order_viol - ov0);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] e[$];
    int         ea[$];
    int         b0, r0, d0, a;
    b0 = got_q.size(); r0 = req_q.size();
    @(posedge clk); #1;
    man_in = 30'($urandom);
    man_load = 1'b1;
    @(posedge clk); #1;
    man_load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (got_q.size() != b0 || req_q.size() != r0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_load: got %0d bytes %0d requests valid=%b busy=%b required 0",
                         got_q.size() - b0, req_q.size() - r0, tx_valid, busy);
    end
    for (int k = 0; k < 2; k++) begin
      a = 300 + 40 * k;
      lat = (k == 0) ? 1 : 7;
      lat_rand = 1'b0; rdy_mode = 0;
      b0 = got_q.size(); r0 = req_q.size(); d0 = done_cnt;
      do_start(AW'(a));
      repeat (3) @(posedge clk);
      #1;
      do_start(AW'(900));
      wait_done(d0);
      model_block(a, e, ea);
      n_chk++;
      if (got_q.size() - b0 != e.size() || done_cnt - d0 != 1) begin
        n_fail++; $display("FAIL lat%0d_len: got %0d bytes %0d dones required %0d bytes 1 done",
                           lat, got_q.size() - b0, done_cnt - d0, e.size());
      end
      foreach (e[i]) if (b0 + i < got_q.size()) begin
        n_chk++;
        if (got_q[b0 + i] !== e[i]) begin n_fail++; $display("FAIL lat%0d_byte[%0d]: got %h required %h", lat, i, got_q[b0 + i], e[i]); end
      end
      n_chk++;
      if (req_q.size() - r0 != BW) begin n_fail++; $display("FAIL lat%0d_reqs: got %0d required %0d", lat, req_q.size() - r0, BW); end
      foreach (ea[i]) if (r0 + i < req_q.size()) begin
        n_chk++;
        if (req_q[r0 + i] != ea[i]) begin n_fail++; $display("FAIL lat%0d_addr[%0d]: got %0d required %0d", lat, i, req_q[r0 + i], ea[i]); end
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [7:0] e[$];
    int         ea[$];
    int         b0, r0, d0, c;
    lat = 2; lat_rand = 1'b0; rdy_mode = 0;
    b0 = got_q.size(); r0 = req_q.size(); d0 = done_cnt;
    do_start(AW'(4095));
    wait_done(d0);
    model_block(4095, e, ea);
    n_chk++;
    if (req_q.size() - r0 != 2) begin n_fail++; $display("FAIL wrap_reqs: got %0d required 2", req_q.size() - r0); end
    foreach (ea[i]) if (r0 + i < req_q.size()) begin
      n_chk++;
      if (req_q[r0 + i] != ea[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, req_q[r0 + i], ea[i]); end
    end
    n_chk++;
    if (got_q.size() - b0 != e.size()) begin n_fail++; $display("FAIL wrap_len: got %0d required %0d", got_q.size() - b0, e.size()); end
    foreach (e[i]) if (b0 + i < got_q.size()) begin
      n_chk++;
      if (got_q[b0 + i] !== e[i]) begin n_fail++; $display("FAIL wrap_byte[%0d]: got %h required %h", i, got_q[b0 + i], e[i]); end
    end
    mem_enable = 1'b0;
    b0 = got_q.size(); r0 = req_q.size(); d0 = done_cnt;
    do_start(AW'(100));
    c = 0;
    while (req_q.size() == r0 && c < 20) begin @(posedge clk); c++; end
    #1;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({addressout, request, tx_data, tx_valid, busy, done} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got addr=%h req=%b data=%h valid=%b busy=%b required all 0",
                         addressout, request, tx_data, tx_valid, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    man_in = mem[100];
    man_load = 1'b1;
    @(posedge clk); #1;
    man_load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (got_q.size() != b0 || req_q.size() != r0 + 1 || tx_valid !== 1'b0 || busy !== 1'b0 || done_cnt != d0) begin
      n_fail++; $display("FAIL late_load: got %0d bytes %0d requests valid=%b busy=%b required 0 bytes 1 request idle",
                         got_q.size() - b0, req_q.size() - r0, tx_valid, busy);
    end
    mem_enable = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] e[$];
    int         ea[$];
    int         b0, r0, d0, a, sv0, ov0;
    sv0 = stall_viol; ov0 = order_viol;
    lat_rand = 1'b1; rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(0, 4095));
      for (int w = 0; w < BW; w++) mem[(a + w) % 4096] = 30'($urandom);
      b0 = got_q.size(); r0 = req_q.size(); d0 = done_cnt;
      do_start(AW'(a));
      wait_done(d0);
      model_block(a, e, ea);
      n_chk++;
      if (got_q.size() - b0 != e.size() || req_q.size() - r0 != BW || done_cnt - d0 != 1) begin
        n_fail++; $display("FAIL rand%0d_len: got %0d bytes %0d reqs %0d dones required %0d/%0d/1",
                           k, got_q.size() - b0, req_q.size() - r0, done_cnt - d0, e.size(), BW);
      end
      foreach (e[i]) if (b0 + i < got_q.size()) begin
        n_chk++;
        if (got_q[b0 + i] !== e[i]) begin n_fail++; $display("FAIL rand%0d_byte[%0d]: got %h required %h", k, i, got_q[b0 + i], e[i]); end
      end
      foreach (ea[i]) if (r0 + i < req_q.size()) begin
        n_chk++;
        if (req_q[r0 + i] != ea[i]) begin n_fail++; $display("FAIL rand%0d_addr[%0d]: got %0d required %0d", k, i, req_q[r0 + i], ea[i]); end
      end
    end
    lat_rand = 1'b0; rdy_mode = 0;
    n_chk++;
    if (stall_viol != sv0 || order_viol != ov0 || busy_viol != 0) begin
      n_fail++; $display("FAIL rand_protocol: got %0d unstable stalls, %0d early requests, %0d busy-with-done required 0",
                         stall_viol - sv0, order_viol - ov0, busy_viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 30'($urandom);
    mem[8]  = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
    mem[9]  = {6'd6, 6'd7, 6'd10, 6'd11, 6'd12};
    mem[50] = {6'd31, 6'd32, 6'd33, 6'd34, 6'd35};
    mem[51] = {6'd36, 6'd37, 6'd30, 6'd31, 6'd32};
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
